// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock and keeps the
// carry in a register between chunks, with start/busy/done handshake and flags.
module seq_chunk_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned OW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic             carry;

  logic             load_c, step_c, last_c;
  logic [OW-1:0]    off;
  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   cs;
  logic [WIDTH-1:0] acc_n;
  logic             msb_cin;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    case (state)
      IDLE: load_c = start;
      RUN: begin
        step_c = 1'b1;
        last_c = (idx == IW'(NCHUNK - 1));
      end
      default: ;
    endcase
  end

  // One chunk of the ripple add; msb_cin is only meaningful on the last chunk
  always_comb begin
    off     = OW'(idx * CHUNK);
    ca      = op_a[off +: CHUNK];
    cb      = op_b[off +: CHUNK];
    cs      = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    acc_n   = acc;
    acc_n[off +: CHUNK] = cs[CHUNK-1:0];
    msb_cin = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_c;
      if (load_c) begin
        op_a  <= in1;
        op_b  <= sub ? ~in2 : in2;
        carry <= sub | cin;
        idx   <= '0;
      end
      if (step_c) begin
        acc   <= acc_n;
        carry <= cs[CHUNK];
        idx   <= last_c ? '0 : idx + IW'(1);
      end
      if (last_c) begin
        sum      <= acc_n;
        cout     <= cs[CHUNK];
        overflow <= msb_cin ^ cs[CHUNK];
        zero     <= (acc_n == '0);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Scoreboard bench for seq_chunk_addsub at CHUNK=8, 32 and 1.
module tb_seq_chunk_addsub;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic        sub, cin;
  logic [31:0] in1, in2;
  logic        busy_w [3];
  logic        done_w [3];
  logic [31:0] sum_w  [3];
  logic        cout_w [3];
  logic        ov_w   [3];
  logic        zero_w [3];

  int   cyc = 0;
  int   ncmp = 0;
  int   nbad = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_chunk_addsub #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]),
    .overflow(ov_w[0]), .zero(zero_w[0]));

  seq_chunk_addsub #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]),
    .overflow(ov_w[1]), .zero(zero_w[1]));

  seq_chunk_addsub #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]),
    .overflow(ov_w[2]), .zero(zero_w[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop the expectation whenever a DUT pulses done
  task automatic check_one(input int d);
    exp_t e;
    bit   have = 1'b0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      ncmp++;
      nbad++;
      $display("FAIL unexpected_done dut%0d: got done=1 expected done=0 (t=%0t)", d, $time);
    end else begin
      chk($sformatf("latency dut%0d", d), 64'(cyc), 64'(e.cyc));
      chk($sformatf("sum dut%0d", d), 64'(sum_w[d]), 64'(e.s));
      chk($sformatf("cout dut%0d", d), 64'(cout_w[d]), 64'(e.co));
      chk($sformatf("overflow dut%0d", d), 64'(ov_w[d]), 64'(e.ov));
      chk($sformatf("zero dut%0d", d), 64'(zero_w[d]), 64'(e.z));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (done_w[d] === 1'b1) check_one(d);
  end

  // Drive one start pulse (called at a negedge); returns one negedge later
  task automatic issue(input int d, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [31:0] es, input logic eco, input logic eov,
                       input logic ez, input bit push);
    exp_t e;
    int   n;
    n = (d == 0) ? 4 : (d == 1) ? 1 : 32;
    sub = s; in1 = a; in2 = b; cin = c;
    start_v = 3'b001 << d;
    e = '{s: es, co: eco, ov: eov, z: ez, cyc: cyc + 1 + n};
    if (push) begin
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(negedge clk);
    start_v = '0;
  endtask

  // Full run on the CHUNK=8 instance with busy and result-hold checks
  task automatic run_main(input logic s, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] es, input logic eco, input logic eov, input logic ez,
                          input logic [31:0] prev);
    issue(0, s, a, b, c, es, eco, eov, ez, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("busy_run", 64'(busy_w[0]), 64'd1);
      chk("sum_hold", 64'(sum_w[0]), 64'(prev));
      @(negedge clk);
    end
    chk("busy_after", 64'(busy_w[0]), 64'd0);
    chk("done_at_4", 64'(done_w[0]), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_w[0]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_v = '0; sub = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", 64'(busy_w[d]), 64'd0);
      chk("reset_done", 64'(done_w[d]), 64'd0);
      chk("reset_sum", 64'(sum_w[d]), 64'd0);
      chk("reset_flags", 64'({cout_w[d], ov_w[d], zero_w[d]}), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_main(1'b0, 32'h7000_0000, 32'h7FFF_FFFF, 1'b0, 32'hEFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
    run_main(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hEFFF_FFFF);
    run_main(1'b1, 32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h0);
    run_main(1'b1, 32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);

    // Start while busy is ignored; start in the done cycle chains a new op
    issue(0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start_v = 3'b001; sub = 1'b1; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
    @(negedge clk);
    start_v = '0;
    chk("sum_hold_overlap", 64'(sum_w[0]), 64'h7FFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("done_b2b", 64'(done_w[0]), 64'd1);
    issue(0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("busy_b2b", 64'(busy_w[0]), 64'd1);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-run aborts without a done pulse
    issue(0, 1'b0, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_sum", 64'(sum_w[0]), 64'd0);
    chk("abort_flags", 64'({cout_w[0], ov_w[0], zero_w[0], done_w[0]}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_main(1'b0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 32'h0);

    // Single-cycle build
    issue(1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    issue(1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Bit-serial build
    issue(2, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (34) @(negedge clk);
    issue(2, 1'b1, 32'd3, 32'd2, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (34) @(negedge clk);

    chk("pending dut0", 64'(q0.size()), 64'd0);
    chk("pending dut1", 64'(q1.size()), 64'd0);
    chk("pending dut2", 64'(q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/seq_chunk_addsub.md
Name: seq_chunk_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; next generation of the 32-bit ripple-carry adder in the step2 datapath.
- Processes CHUNK bits per clock, rippling the carry through a register between chunks.
- Adds a subtract mode, a start/busy/done handshake, and overflow/zero flags.
- Sits beside the ALU for area-constrained builds, where a full-width combinational carry chain is too long for the clock period.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. Must be at least 1 and must divide WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local constant equal to the number of compute cycles. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when idle.
- sub  input  1  0 = in1+in2+cin; 1 = in1-in2 (computed as in1 + ~in2 + 1, cin ignored).
- in1  input  WIDTH  first operand.
- in2  input  WIDTH  second operand.
- cin  input  1  carry-in; add mode only.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, chunk index=0.
  - busy, done, sum, cout, overflow, zero = 0.
  - Operand, carry and accumulator registers = 0.
  - Reset mid-operation aborts it; no done pulse follows.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 at edge E0:
  - Latch in1.
  - Latch in2, inverted if sub=1.
  - Carry register = (sub ? 1 : cin).
  - Index=0; go to RUN.
  - done clears at E0 if it was set.
- RUN, each edge Ek (k=1..NCHUNK):
  - Add chunk k-1 (bits [k*CHUNK-1:(k-1)*CHUNK]) of both latched operands plus the carry register.
  - Write the CHUNK-bit result into an internal accumulator.
  - Update the carry register; increment the index.
- At edge E_NCHUNK:
  - sum <= full accumulator including the final chunk.
  - cout <= final carry.
  - overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero <= (final sum == 0).
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle after edge E_NCHUNK, i.e. NCHUNK cycles after the start edge. Throughput is one operation per NCHUNK cycles.
- done lasts exactly one cycle unless a new start is accepted in that cycle; it clears at the next edge in either case.
- start in the done cycle is accepted (state is IDLE), giving back-to-back operation.
- start while busy=1 is ignored; there is no queueing.
- in1, in2, cin, sub may change freely during RUN; only the values latched at E0 are used.
- sum, cout, overflow and zero hold the previous result throughout RUN and change only at E_NCHUNK.
- All result bits wrap modulo 2^WIDTH.
- CHUNK=WIDTH is legal: NCHUNK=1, done appears one cycle after start.

Test Plan:
- WIDTH=32, CHUNK=8, add, in1=0x70000000, in2=0x7FFFFFFF, cin=0 -> done exactly 4 cycles after the start edge; sum=0xEFFFFFFF, cout=0, overflow=1, zero=0; busy high for those 4 cycles.
- Add, in1=0xFFFFFFFF, in2=0x00000000, cin=1 -> sum=0x00000000, cout=1, zero=1, overflow=0. Checks carry rippling across all 4 chunk boundaries.
- sub=1, in1=5, in2=7, cin=1 -> sum=0xFFFFFFFE, cout=0, overflow=0. Then sub=1, in1=0x80000000, in2=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- start pulsed again at cycle 2 of a run, with in1/in2 changed mid-run -> that start is ignored; the first result is unaffected. A start in the done cycle begins a second operation whose done arrives 4 cycles later.
- rst_n driven low asynchronously (between clock edges) during cycle 2 of a run -> all outputs go to 0 immediately; no done pulse; the next start completes normally.
- Rebuild with CHUNK=32 and CHUNK=1, random operands against a reference model -> done latency 1 and 32 cycles respectively; results bit-exact.
